// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded write-port arbiter for async_fifo; ports: wr_clk/wr_rst, req_valid/req_data/req_ready per requester, full/half_full from FIFO, wr_en/wr_data to FIFO, grant/busy/burst_done status
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 4,
  parameter logic [NUM_REQ-1:0] HIPRI_MASK = NUM_REQ'(1)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  input  logic                          half_full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          burst_done
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_d;
  logic [IW-1:0] last_grant, sel, idx;
  logic [BW-1:0] beat_cnt;
  logic [NUM_REQ-1:0] elig;
  logic lo_pri, stall, end_burst;
  assign busy = state == GRANT;
  assign elig = req_valid & (half_full ? HIPRI_MASK : '1);
  // last_grant doubles as the granted index while busy
  assign lo_pri = ~HIPRI_MASK[last_grant];
  assign stall = full | (half_full & lo_pri);
  assign wr_en = busy & req_valid[last_grant] & ~stall;
  assign wr_data = busy ? req_data[last_grant*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign req_ready = wr_en ? grant : '0;
  // a dropped valid can only coincide with wr_en=0, so rule ordering collapses to an OR
  assign end_burst = busy & ((half_full & lo_pri) | (wr_en & (beat_cnt == BW'(MAX_BURST - 1))) | ~req_valid[last_grant]);
  // scan downward so the lowest offset above last_grant wins
  always_comb begin
    sel = last_grant;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (elig[idx]) sel = idx;
    end
  end
  always_comb state_d = busy ? (end_burst ? IDLE : GRANT) : (|elig ? GRANT : IDLE);
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state <= IDLE;
      grant <= '0;
      beat_cnt <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      burst_done <= 1'b0;
    end else begin
      state <= state_d;
      burst_done <= end_burst;
      if (!busy && |elig) begin
        grant <= NUM_REQ'(1) << sel;
        last_grant <= sel;
        beat_cnt <= '0;
      end else if (end_burst) begin
        grant <= '0;
        beat_cnt <= '0;
      end else if (wr_en) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and scoreboard tests for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  logic wr_clk = 1'b0;
  logic wr_rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0] req_ready;
  logic full = 1'b0;
  logic half_full = 1'b0;
  logic wr_en;
  logic [7:0] wr_data;
  logic [3:0] grant;
  logic busy;
  logic burst_done;
  int total = 0;
  int bad = 0;

  fifo_wr_arbiter dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .full(full), .half_full(half_full), .wr_en(wr_en),
    .wr_data(wr_data), .grant(grant), .busy(busy), .burst_done(burst_done)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic tick;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset;
    wr_rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    full = 1'b0;
    half_full = 1'b0;
    tick;
    wr_rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    total++; if (grant !== 4'h0 || busy !== 1'b0) begin bad++; $display("FAIL reset_state grant=%h busy=%b want grant=0 busy=0", grant, busy); end
    total++; if (wr_en !== 1'b0 || req_ready !== 4'h0 || wr_data !== 8'h0) begin bad++; $display("FAIL reset_outputs wr_en=%b ready=%h data=%h want 0", wr_en, req_ready, wr_data); end
    total++; if (burst_done !== 1'b0) begin bad++; $display("FAIL reset_burst_done got=%b want=0", burst_done); end
  endtask

  task automatic test_reset_mid_burst;
    do_reset;
    req_valid = 4'b0010;
    req_data[15:8] = 8'h21;
    tick; #1;
    total++; if (grant !== 4'b0010 || wr_en !== 1'b1) begin bad++; $display("FAIL rstmid_grant grant=%h wr_en=%b want 2/1", grant, wr_en); end
    tick;
    tick;
    wr_rst = 1'b1;
    req_valid = 4'b0011;
    tick; #1;
    total++; if (grant !== 4'h0 || busy !== 1'b0 || wr_en !== 1'b0 || burst_done !== 1'b0) begin bad++; $display("FAIL rstmid_cleared grant=%h busy=%b wr_en=%b bd=%b want 0", grant, busy, wr_en, burst_done); end
    wr_rst = 1'b0;
    tick; #1;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rstmid_first_grant got=%h want=1", grant); end
  endtask

  task automatic test_round_robin;
    int writes[4];
    int ph, r;
    logic [3:0] eg;
    logic [7:0] ed;
    do_reset;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_data[i*8 +: 8] = 8'(16 * i);
      writes[i] = 0;
    end
    for (int c = 0; c < 25; c++) begin
      #1;
      ph = c % 5;
      r = (c / 5) % 4;
      eg = (ph == 0) ? 4'h0 : 4'(1 << r);
      ed = (ph == 0) ? 8'h0 : 8'(16 * r);
      total++;
      if (grant !== eg || wr_en !== (ph != 0) || burst_done !== (ph == 0 && c > 0) || wr_data !== ed || req_ready !== eg) begin
        bad++;
        $display("FAIL rr_cycle%0d grant=%h wr_en=%b bd=%b data=%h ready=%h want grant=%h data=%h", c, grant, wr_en, burst_done, wr_data, req_ready, eg, ed);
      end
      for (int j = 0; j < 4; j++) if (req_ready[j]) writes[j]++;
      tick;
    end
    total++; if (writes[0] !== 8 || writes[1] !== 4 || writes[2] !== 4 || writes[3] !== 4) begin bad++; $display("FAIL rr_counts got=%0d,%0d,%0d,%0d want=8,4,4,4", writes[0], writes[1], writes[2], writes[3]); end
  endtask

  task automatic test_short_burst;
    int n = 0;
    do_reset;
    req_valid = 4'b0100;
    req_data[23:16] = 8'hA0;
    #1;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL short_idle wr_en=%b want=0", wr_en); end
    tick; #1;
    total++; if (grant !== 4'b0100 || wr_en !== 1'b1 || wr_data !== 8'hA0) begin bad++; $display("FAIL short_w0 grant=%h wr_en=%b data=%h want 4/1/a0", grant, wr_en, wr_data); end
    n += int'(wr_en);
    tick;
    req_data[23:16] = 8'hA1;
    #1;
    total++; if (wr_en !== 1'b1 || wr_data !== 8'hA1) begin bad++; $display("FAIL short_w1 wr_en=%b data=%h want 1/a1", wr_en, wr_data); end
    n += int'(wr_en);
    tick;
    req_valid = 4'b1001;
    req_data[31:24] = 8'h3C;
    req_data[7:0] = 8'h0C;
    #1;
    total++; if (wr_en !== 1'b0 || req_ready !== 4'h0 || grant !== 4'b0100) begin bad++; $display("FAIL short_drop wr_en=%b ready=%h grant=%h want 0/0/4", wr_en, req_ready, grant); end
    n += int'(wr_en);
    tick; #1;
    total++; if (busy !== 1'b0 || burst_done !== 1'b1 || grant !== 4'h0) begin bad++; $display("FAIL short_end busy=%b bd=%b grant=%h want 0/1/0", busy, burst_done, grant); end
    total++; if (n !== 2) begin bad++; $display("FAIL short_writes got=%0d want=2", n); end
    tick; #1;
    total++; if (grant !== 4'b1000 || wr_data !== 8'h3C) begin bad++; $display("FAIL short_next grant=%h data=%h want 8/3c", grant, wr_data); end
  endtask

  task automatic test_back_pressure;
    int n = 0;
    do_reset;
    req_valid = 4'b1000;
    req_data[31:24] = 8'h30;
    tick; #1;
    total++; if (grant !== 4'b1000 || wr_en !== 1'b1) begin bad++; $display("FAIL bp_w0 grant=%h wr_en=%b want 8/1", grant, wr_en); end
    n += int'(wr_en);
    tick;
    req_data[31:24] = 8'h31;
    #1;
    n += int'(wr_en);
    tick;
    req_data[31:24] = 8'h32;
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (wr_en !== 1'b0 || req_ready !== 4'h0 || grant !== 4'b1000 || busy !== 1'b1) begin bad++; $display("FAIL bp_stall%0d wr_en=%b ready=%h grant=%h busy=%b want 0/0/8/1", i, wr_en, req_ready, grant, busy); end
      n += int'(wr_en);
      tick;
    end
    full = 1'b0;
    #1;
    total++; if (wr_en !== 1'b1 || wr_data !== 8'h32) begin bad++; $display("FAIL bp_resume wr_en=%b data=%h want 1/32", wr_en, wr_data); end
    n += int'(wr_en);
    tick;
    req_data[31:24] = 8'h33;
    #1;
    n += int'(wr_en);
    tick; #1;
    total++; if (busy !== 1'b0 || burst_done !== 1'b1) begin bad++; $display("FAIL bp_end busy=%b bd=%b want 0/1", busy, burst_done); end
    total++; if (n !== 4) begin bad++; $display("FAIL bp_writes got=%0d want=4", n); end
  endtask

  task automatic test_half_full;
    bit seen = 0;
    bit found = 0;
    do_reset;
    req_valid = 4'b0010;
    req_data[15:8] = 8'h11;
    tick; #1;
    total++; if (grant !== 4'b0010 || wr_en !== 1'b1) begin bad++; $display("FAIL hf_grant1 grant=%h wr_en=%b want 2/1", grant, wr_en); end
    half_full = 1'b1;
    #1;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL hf_nowrite wr_en=%b want=0", wr_en); end
    tick; #1;
    total++; if (busy !== 1'b0 || burst_done !== 1'b1 || grant !== 4'h0) begin bad++; $display("FAIL hf_preempt busy=%b bd=%b grant=%h want 0/1/0", busy, burst_done, grant); end
    req_valid = 4'b0011;
    tick; #1;
    total++; if (grant !== 4'b0001 || wr_en !== 1'b1) begin bad++; $display("FAIL hf_hipri grant=%h wr_en=%b want 1/1", grant, wr_en); end
    for (int i = 0; i < 12; i++) begin
      tick; #1;
      if (grant[1]) seen = 1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL hf_throttle lowpri_granted=%b want=0", seen); end
    half_full = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick; #1;
      if (grant === 4'b0010) found = 1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL hf_release lowpri_granted=%b want=1", found); end
  endtask

  task automatic test_scoreboard;
    logic [7:0] q[$];
    int sent[4];
    int exp_seq[4];
    bit pend[4];
    int reads = 0;
    int cnt_ready = 0;
    int cnt_wr = 0;
    bit rd, w;
    logic [7:0] wd, d;
    logic [3:0] rr;
    int id;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0;
      exp_seq[i] = 0;
      pend[i] = 0;
    end
    for (int cyc = 0; cyc < 20000 && reads < 400; cyc++) begin
      full = q.size() >= 16;
      half_full = q.size() >= 8;
      rd = q.size() > 0 && ($urandom % 3 != 0);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && sent[i] < 100 && ($urandom % 4 != 0)) begin
          pend[i] = 1;
          req_data[i*8 +: 8] = {2'(i), 6'(sent[i])};
        end
        req_valid[i] = pend[i];
      end
      #1;
      total++; if (wr_en === 1'b1 && full) begin bad++; $display("FAIL sb_write_full cyc=%0d wr_en=%b full=%b", cyc, wr_en, full); end
      total++; if (req_ready !== (wr_en ? grant : 4'h0)) begin bad++; $display("FAIL sb_ready cyc=%0d ready=%h want=%h", cyc, req_ready, wr_en ? grant : 4'h0); end
      w = wr_en;
      wd = wr_data;
      rr = req_ready;
      tick;
      if (rd) begin
        d = q.pop_front();
        id = int'(d[7:6]);
        total++; if (d[5:0] !== 6'(exp_seq[id])) begin bad++; $display("FAIL sb_order req=%0d seq=%0d want=%0d", id, d[5:0], exp_seq[id] % 64); end
        exp_seq[id]++;
        reads++;
      end
      if (w) begin
        q.push_back(wd);
        cnt_wr++;
      end
      for (int i = 0; i < 4; i++) if (rr[i]) begin
        pend[i] = 0;
        sent[i]++;
        cnt_ready++;
      end
    end
    total++; if (reads !== 400) begin bad++; $display("FAIL sb_reads got=%0d want=400", reads); end
    total++; if (cnt_wr !== cnt_ready || cnt_wr !== 400) begin bad++; $display("FAIL sb_counts writes=%0d readies=%0d want=400", cnt_wr, cnt_ready); end
    total++; if (exp_seq[0] !== 100 || exp_seq[1] !== 100 || exp_seq[2] !== 100 || exp_seq[3] !== 100) begin bad++; $display("FAIL sb_per_req got=%0d,%0d,%0d,%0d want=100 each", exp_seq[0], exp_seq[1], exp_seq[2], exp_seq[3]); end
  endtask

  initial begin
    test_reset;
    test_reset_mid_burst;
    test_round_robin;
    test_short_burst;
    test_back_pressure;
    test_half_full;
    test_scoreboard;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
